// File: rtl/reaction_timer.sv
// Reaction-time trial: random wait, stimulus LED, millisecond count to button press.
// Optional DEBOUNCE_EN adds a tick-based debounce filter after the button synchronizer.
module reaction_timer #(
    parameter int TICKS_PER_MS     = 50000,
    parameter int DELAY_MIN_MS     = 1000,
    parameter int DELAY_RANGE_BITS = 10,
    parameter int DEBOUNCE_MS      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic        Button,
    output logic        Led,
    output logic [14:0] Time,
    output logic        Valid,
    output logic        Foul,
    output logic        Busy
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int DW = $clog2(DELAY_MIN_MS + (1 << DELAY_RANGE_BITS) + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ARMED,
        S_DONE,
        S_FOUL
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  pre_q;
    logic           tick;
    logic [15:0]    lfsr_q;
    logic           lfsr_fb;
    logic           sync1_q, sync2_q;
    logic           lvl, lvl_prev_q, press_q;
    logic [DW-1:0]  delay_q, delay_d;
    logic [DW-1:0]  rand_ms;
    logic [14:0]    ms_q, ms_d;
    logic [14:0]    time_q, time_d;
    logic           foul_q, foul_d;
    logic           valid_q, valid_d;
    logic           start_acc;

    assign tick    = (pre_q == PW'(TICKS_PER_MS - 1));
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    generate
        if (DELAY_RANGE_BITS > 0) begin : g_rand
            assign rand_ms = DW'(lfsr_q[DELAY_RANGE_BITS-1:0]);
        end else begin : g_fixed
            assign rand_ms = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q     <= 16'hACE1;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            lfsr_q     <= {lfsr_q[14:0], lfsr_fb};
            sync1_q    <= Button;
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl;
            press_q    <= lvl & ~lvl_prev_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_MS + 1);
    logic           filt_q;
    logic [DBW-1:0] db_cnt_q;

    // Filtered level flips on the DEBOUNCE_MS-th consecutive tick of disagreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q   <= 1'b0;
            db_cnt_q <= '0;
        end else if (sync2_q == filt_q) begin
            db_cnt_q <= '0;
        end else if (tick) begin
            if (db_cnt_q == DBW'(DEBOUNCE_MS - 1)) begin
                filt_q   <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DBW'(1);
            end
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else if (start_acc || tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        ms_d      = ms_q;
        time_d    = time_q;
        foul_d    = foul_q;
        valid_d   = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_FOUL: begin
                if (Start) begin
                    state_d   = S_WAIT;
                    delay_d   = DW'(DELAY_MIN_MS) + rand_ms;
                    ms_d      = '0;
                    foul_d    = 1'b0;
                    start_acc = 1'b1;
                end
            end
            S_WAIT: begin
                if (press_q) begin
                    state_d = S_FOUL;
                    foul_d  = 1'b1;
                    time_d  = '0;
                    valid_d = 1'b1;
                end else if (tick) begin
                    delay_d = delay_q - DW'(1);
                    if (delay_q == DW'(1)) begin
                        state_d = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (press_q) begin
                    state_d = S_DONE;
                    time_d  = ms_q;
                    valid_d = 1'b1;
                end else if (tick) begin
                    ms_d = ms_q + 15'd1;
                    // Saturate at 7FFF rather than wrap.
                    if (ms_q == 15'h7FFE) begin
                        state_d = S_DONE;
                        time_d  = 15'h7FFF;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            delay_q <= '0;
            ms_q    <= '0;
            time_q  <= '0;
            foul_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            ms_q    <= ms_d;
            time_q  <= time_d;
            foul_q  <= foul_d;
            valid_q <= valid_d;
        end
    end

    assign Led   = (state_q == S_ARMED);
    assign Busy  = (state_q == S_WAIT) || (state_q == S_ARMED);
    assign Time  = time_q;
    assign Foul  = foul_q;
    assign Valid = valid_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: trials are predicted from edge arithmetic,
// a negedge monitor compares Valid results and per-cycle Led/Busy.
module tb_reaction_timer;

    localparam int T = 2;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Start = 1'b0;
    logic        Button = 1'b0;
    logic        Led;
    logic [14:0] Time;
    logic        Valid;
    logic        Foul;
    logic        Busy;

    reaction_timer #(
        .TICKS_PER_MS(T),
        .DELAY_MIN_MS(D),
        .DELAY_RANGE_BITS(0),
        .DEBOUNCE_MS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Start(Start),
        .Button(Button),
        .Led(Led),
        .Time(Time),
        .Valid(Valid),
        .Foul(Foul),
        .Busy(Busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          edge_n;
        logic [14:0] t;
        logic        foul;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   start_e = 0;
    int   arm_e = 0;
    int   end_e = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("led", 32'(Led), 32'(cyc >= arm_e && cyc < end_e));
            chk("busy", 32'(Busy), 32'(cyc >= start_e && cyc < end_e));
            if (Valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid at cycle %0d: got Valid=1 expected none", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("valid_cycle", 32'(cyc), 32'(e.edge_n));
                    chk("time", 32'(Time), 32'(e.t));
                    chk("foul", 32'(Foul), 32'(e.foul));
                end
            end
        end
    end

    // n_off: edge offset from Start at which Button is first sampled high (-1: never).
    // pre: Button pulse timed so its press event coincides with the Start edge.
    // busy_off/rst_off: offsets for a Start pulse while busy / a reset pulse (-1: none).
    task automatic trial(input int n_off, input bit pre, input int busy_off, input int rst_off);
        int   s, a, n, p, to, ev, r, be, last, nx;
        exp_t e;
        s  = cyc + 5;
        a  = s + D * T;
        to = a + 32767 * T;
        n  = (n_off >= 0) ? s + n_off : 0;
        p  = (n_off >= 0) ? n + 3 : 0;
        r  = (rst_off >= 0) ? s + rst_off : 0;
        if (r != 0) begin
            ev = r;
        end else if (n_off >= 0 && p <= a) begin
            ev = p;
            e.t = 15'd0;
            e.foul = 1'b1;
        end else if (n_off >= 0 && p <= to) begin
            ev = p;
            e.t = 15'((p - a - 1) / T);
            e.foul = 1'b0;
        end else begin
            ev = to;
            e.t = 15'h7FFF;
            e.foul = 1'b0;
        end
        if (r == 0) begin
            e.edge_n = ev;
            sbq.push_back(e);
        end
        be = (busy_off >= 0) ? s + busy_off : 0;
        if (be > ev) be = ev;
        start_e = s;
        arm_e   = a;
        end_e   = ev;
        last    = ev + 4;
        while (cyc < last) begin
            nx     = cyc + 1;
            Start  = (nx == s) || (be != 0 && nx == be);
            Button = (n_off >= 0 && nx >= n && nx <= p) || (pre && nx >= s - 3 && nx <= s + 1);
            rst    = (r != 0 && nx == r);
            @(negedge clk);
            if (r != 0 && cyc == r) begin
                chk("rst_led", 32'(Led), 32'd0);
                chk("rst_busy", 32'(Busy), 32'd0);
                chk("rst_time", 32'(Time), 32'd0);
                chk("rst_valid", 32'(Valid), 32'd0);
                chk("rst_foul", 32'(Foul), 32'd0);
            end
        end
        Start  = 1'b0;
        Button = 1'b0;
        rst    = 1'b0;
        chk("missing_valid", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    initial begin
        int mode;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("init_led", 32'(Led), 32'd0);
        chk("init_busy", 32'(Busy), 32'd0);
        chk("init_time", 32'(Time), 32'd0);
        chk("init_valid", 32'(Valid), 32'd0);
        chk("init_foul", 32'(Foul), 32'd0);
        mon_en = 1'b1;

        trial(20, 1'b0, -1, -1);            // normal press in ARMED
        trial(3, 1'b0, -1, -1);             // press coincides with arming tick: foul wins
        trial(1, 1'b0, -1, -1);             // early foul
        trial(4, 1'b0, -1, -1);             // earliest press in ARMED, Time=0
        trial(26, 1'b1, 5, -1);             // press on Start edge ignored, Start while busy ignored
        for (int i = 0; i < 12; i++) begin
            mode = int'($urandom_range(2, 0));
            if (mode == 0)
                trial(int'($urandom_range(3, 1)), 1'b0, -1, -1);
            else if (mode == 1)
                trial(int'($urandom_range(204, 4)), 1'b0, -1, -1);
            else
                trial(int'($urandom_range(120, 4)), 1'b0, int'($urandom_range(60, 1)), -1);
        end
        trial(-1, 1'b0, 3, D * T + 1 + int'($urandom_range(20, 0)));   // reset while ARMED
        trial(33, 1'b0, -1, -1);            // fresh trial after reset
        trial(-1, 1'b0, 100, -1);           // timeout saturation
        trial(11, 1'b0, -1, -1);            // re-arm after timeout

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
